act_quant_pipe: RTL and testbench
=================================

// Module: act_quant_pipe
// PURPOSE
//  Parametrised activation + requantisation stage between the CIM accumulator array and the
//  next-layer input buffer. Takes NUM_CH signed IN_PRECISION-bit partial sums per vector and
//  applies a selectable activation (ReLU / leaky ReLU / identity), a programmable right shift,
//  optional rounding and saturation to OUT_PRECISION bits. It is a 2-stage valid/ready
//  pipeline, so per-vector config changes are safe mid-stream.
// PARAMETERS
//  NUM_CH         64  channels per vector
//  IN_PRECISION   18  signed input width per channel (two's complement)
//  OUT_PRECISION   4  output width per channel
//  SHIFT_W         5  width of shift control
// PORTS
//  clk        in   1                       clock, all logic on posedge
//  rst_n      in   1                       synchronous active-low reset
//  in_valid   in   1                       input vector valid
//  in_ready   out  1                       block can accept input
//  act_in     in   IN_PRECISION*NUM_CH     ch i at [IN_PRECISION*(i+1)-1 -: IN_PRECISION]
//  mode       in   2                       00 ReLU(unsigned out), 01 leaky ReLU, 10 identity, 11 rsvd(=00)
//  shift      in   SHIFT_W                 arithmetic right-shift amount
//  round_en   in   1                       1: round half up after shift
//  out_valid  out  1                       output vector valid
//  out_ready  in   1                       downstream accepts output
//  act_out    out  OUT_PRECISION*NUM_CH    ch i at [OUT_PRECISION*(i+1)-1 -: OUT_PRECISION]
//  out_sat    out  1                       any channel of current output vector was clamped
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, act_out=0, out_sat=0, stage-1 valid=0; in_ready=0
//   combinationally while rst_n=0. In-flight vectors are discarded, no partial output.
//  Handshake: en = !out_valid | out_ready; in_ready = rst_n & en. Accept on in_valid&in_ready.
//   When en=0 both stages freeze; act_out/out_sat held stable while out_valid&!out_ready.
//   Vector order preserved, no drop/duplication. Latency 2 cycles accept->out_valid unstalled;
//   throughput 1 vector/cycle with out_ready=1.
//  mode/shift/round_en sampled with each accepted vector and carried in the pipeline.
//  Stage 1 (per channel, x = signed act_in): a = ReLU: max(x,0); leaky: x<0 ? x>>>3 : x
//   (arithmetic, floor, so -1 -> -1); identity: x. Register a and config.
//  Stage 2: computed at IN_PRECISION+1 bits, no internal overflow:
//   s = a>>>shift; if round_en && 1<=shift<IN_PRECISION: s += a[shift-1].
//   shift >= IN_PRECISION: s = sign fill (0 or -1), no rounding.
//   Saturate: ReLU -> clamp [0, 2^OUT_PRECISION-1] unsigned; leaky/identity -> clamp
//   [-2^(OUT_PRECISION-1), 2^(OUT_PRECISION-1)-1] two's complement. out_sat = OR of clamps.
//  Prior-generation equivalence: mode=00, shift=IN_PRECISION-1-OUT_PRECISION, round_en=0 gives
//   the MS OUT_PRECISION bits below sign for x>=0, else 0; never saturates.
//  in_valid=1 with in_ready=0: input ignored, upstream must hold. Simultaneous output pop and
//   input accept in same cycle is legal and required for full throughput.
// TESTING (IN=18, OUT=4, NUM_CH=64)
//  Legacy: mode=00 shift=13 round=0, ch0=18'h0A000, ch1=18'h3FFFF -> 2 cycles later ch0=4'h5,
//   ch1=4'h0, out_sat=0.
//  Rounding: mode=10 shift=4 round=1, ch0=24, ch1=23, ch2=-24 -> 4'h2, 4'h1, 4'hF (-1).
//  Saturation: mode=00 shift=0 x=100 -> 4'hF, out_sat=1; mode=10 x=-100 -> 4'h8, out_sat=1.
//  Leaky: mode=01 shift=0, x=-16 -> 4'hE, x=-1 -> 4'hF, x=7 -> 4'h7, out_sat=0.
//  Backpressure: out_ready=0, send A,B,C back-to-back -> A,B accepted, in_ready=0 with A held
//   on act_out; release out_ready -> A,B,C output in order, each exactly once.
//  Reset mid-flight: 2 vectors in pipe, rst_n=0 one cycle -> next cycle out_valid=0, act_out=0,
//   in_ready=0 during reset; first vector after reset emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/act_quant_pipe.sv
// -----------------------------------------------------------------------------
// act_quant_pipe
//   Activation and requantisation stage between the CIM accumulator array and
//   the next-layer input buffer. Each accepted vector carries NUM_CH signed
//   partial sums. Each channel goes through an activation (ReLU, leaky ReLU or
//   identity), then an arithmetic right shift, optional round-half-up and
//   saturation to OUT_PRECISION bits.
//
//   The block is a two-stage valid/ready pipeline. mode, shift and round_en are
//   captured with each vector, so changing the config between vectors is safe.
//
// Ports
//   clk        clock; all logic runs on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept an input vector (held low during reset)
//   act_in     NUM_CH x IN_PRECISION signed partial sums, ch i in slice i
//   mode       00 ReLU (unsigned out), 01 leaky ReLU, 10 identity, 11 = 00
//   shift      arithmetic right-shift amount
//   round_en   round half up after the shift
//   out_valid  output vector valid
//   out_ready  downstream accepts the output vector
//   act_out    NUM_CH x OUT_PRECISION quantised outputs, ch i in slice i
//   out_sat    at least one channel of the current output was clamped
// -----------------------------------------------------------------------------
module act_quant_pipe #(
    parameter int NUM_CH        = 64,
    parameter int IN_PRECISION  = 18,
    parameter int OUT_PRECISION = 4,
    parameter int SHIFT_W       = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_PRECISION*NUM_CH-1:0]  act_in,
    input  logic [1:0]                      mode,
    input  logic [SHIFT_W-1:0]              shift,
    input  logic                            round_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_PRECISION*NUM_CH-1:0] act_out,
    output logic                            out_sat
);

    typedef enum logic [1:0] {
        MODE_RELU  = 2'b00,
        MODE_LEAKY = 2'b01,
        MODE_IDENT = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef struct packed {
        logic                     sat;
        logic [OUT_PRECISION-1:0] q;
    } quant_t;

    // One extra bit of headroom: a shift of 1 plus a rounding increment
    // cannot overflow the working width.
    localparam int EXT_W    = IN_PRECISION + 1;
    localparam int RELU_MAX = (1 << OUT_PRECISION) - 1;
    localparam int SGN_MAX  = (1 << (OUT_PRECISION - 1)) - 1;
    localparam int SGN_MIN  = -(1 << (OUT_PRECISION - 1));

    // Stage 1: activation. Leaky ReLU uses an arithmetic floor shift, so
    // -1 maps to -1 and not to 0.
    function automatic logic signed [IN_PRECISION-1:0] activate(
        input logic signed [IN_PRECISION-1:0] x,
        input mode_e                          m
    );
        // NOTE: every path returns a value. The default arm also covers the
        // reserved mode, so this logic stays combinational and infers no latch.
        case (m)
            MODE_LEAKY: return x[IN_PRECISION-1] ? (x >>> 3) : x;
            MODE_IDENT: return x;
            default:    return x[IN_PRECISION-1] ? '0 : x;
        endcase
    endfunction

    // Stage 2: shift, optional rounding, then saturation.
    function automatic quant_t quantise(
        input logic signed [IN_PRECISION-1:0] a,
        input mode_e                          m,
        input logic [SHIFT_W-1:0]             sh,
        input logic                           rnd
    );
        logic signed [EXT_W-1:0] ae;
        logic signed [EXT_W-1:0] s;
        logic [SHIFT_W-1:0]      sh_m1;
        int                      sv;
        quant_t                  r;
        ae    = {a[IN_PRECISION-1], a};
        sh_m1 = sh - 1'b1;
        if (int'(sh) >= IN_PRECISION) begin
            // Every magnitude bit is shifted out. Only the sign remains,
            // and no rounding is applied.
            s = {EXT_W{a[IN_PRECISION-1]}};
        end else begin
            s = ae >>> sh;
            if (rnd && (sh != '0))
                s = s + {{(EXT_W-1){1'b0}}, ae[sh_m1]};
        end
        sv = int'(s);
        r  = '0;
        if (m == MODE_RELU || m == MODE_RSVD) begin
            if (sv > RELU_MAX) begin
                r.q = OUT_PRECISION'(RELU_MAX);
                r.sat = 1'b1;
            end else if (sv < 0) begin
                r.q = '0;
                r.sat = 1'b1;
            end else begin
                r.q = OUT_PRECISION'(sv);
            end
        end else begin
            if (sv > SGN_MAX) begin
                r.q = OUT_PRECISION'(SGN_MAX);
                r.sat = 1'b1;
            end else if (sv < SGN_MIN) begin
                r.q = OUT_PRECISION'(SGN_MIN);
                r.sat = 1'b1;
            end else begin
                r.q = OUT_PRECISION'(sv);
            end
        end
        return r;
    endfunction

    // Pipeline state
    logic                            s1_valid;
    logic signed [IN_PRECISION-1:0]  s1_a [NUM_CH];
    mode_e                           s1_mode;
    logic [SHIFT_W-1:0]              s1_shift;
    logic                            s1_round;

    logic signed [IN_PRECISION-1:0]  a_next [NUM_CH];
    quant_t                          qres   [NUM_CH];
    logic [OUT_PRECISION*NUM_CH-1:0] s2_q;
    logic [NUM_CH-1:0]               sat_vec;
    logic                            en;

    // Both stages advance together unless a held output blocks them.
    assign en       = !out_valid || out_ready;
    assign in_ready = rst_n && en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign a_next[i] = activate(act_in[IN_PRECISION*i +: IN_PRECISION], mode_e'(mode));
        assign qres[i]   = quantise(s1_a[i], s1_mode, s1_shift, s1_round);
        assign s2_q[OUT_PRECISION*i +: OUT_PRECISION] = qres[i].q;
        assign sat_vec[i] = qres[i].sat;
    end

    // Control and output registers. Reset discards in-flight vectors.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the clock edge.
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            act_out   <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (s1_valid) begin
                act_out <= s2_q;
                out_sat <= |sat_vec;
            end
        end
    end

    // NOTE: the stage-1 data registers are deliberately left without a reset.
    // They are only read while s1_valid is set, so clearing them would only
    // add reset fan-out across NUM_CH x IN_PRECISION flops.
    always_ff @(posedge clk) begin
        if (rst_n && en && in_valid) begin
            s1_a     <= a_next;
            s1_mode  <= mode_e'(mode);
            s1_shift <= shift;
            s1_round <= round_en;
        end
    end

endmodule

// File: tb/tb_act_quant_pipe.sv
module tb_act_quant_pipe;

    localparam int N  = 64;
    localparam int IW = 18;
    localparam int OW = 4;
    localparam int SW = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IW*N-1:0]   act_in;
    logic [1:0]        mode;
    logic [SW-1:0]     shift;
    logic              round_en;
    logic              out_valid;
    logic              out_ready;
    logic [OW*N-1:0]   act_out;
    logic              out_sat;

    act_quant_pipe #(.NUM_CH(N), .IN_PRECISION(IW), .OUT_PRECISION(OW), .SHIFT_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_in    (act_in),
        .mode      (mode),
        .shift     (shift),
        .round_en  (round_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_out   (act_out),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channels 0..3 carry stimulus. All other channels are zero, so their
    // outputs are zero in every mode.
    typedef struct {
        string             name;
        logic [1:0]        mode;
        logic [SW-1:0]     shift;
        logic              rnd;
        logic [3:0][IW-1:0] ch;
        logic [3:0][OW-1:0] q;
        logic              sat;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [OW*N-1:0] got, input logic [OW*N-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] m, input int sh, input logic r,
                                input int c0, input int c1, input int c2, input int c3,
                                input logic [3:0] q0, input logic [3:0] q1,
                                input logic [3:0] q2, input logic [3:0] q3, input logic s);
        vec_t v;
        v.name  = name;
        v.mode  = m;
        v.shift = SW'(sh);
        v.rnd   = r;
        v.ch[0] = IW'(c0); v.ch[1] = IW'(c1); v.ch[2] = IW'(c2); v.ch[3] = IW'(c3);
        v.q[0]  = q0;      v.q[1]  = q1;      v.q[2]  = q2;      v.q[3]  = q3;
        v.sat   = s;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        act_in = '0;
        for (int i = 0; i < 4; i++) act_in[IW*i +: IW] = v.ch[i];
        mode     = v.mode;
        shift    = v.shift;
        round_en = v.rnd;
    endtask

    function automatic logic [OW*N-1:0] expected(input vec_t v);
        logic [OW*N-1:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) e[OW*i +: OW] = v.q[i];
        return e;
    endfunction

    // Present one vector with out_ready high. Then check the 2-cycle
    // latency, the data and the saturation flag.
    task automatic apply_vec(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, " in_ready"}, {255'b0, in_ready}, 1);
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, (OW*N)'(lat), 2);
        check({v.name, " act_out"}, act_out, expected(v));
        check({v.name, " out_sat"}, {255'b0, out_sat}, {255'b0, v.sat});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t a, b, c;
        int   got[$];
        logic c_acc;

        // mk(name, mode, shift, round, ch0..ch3, q0..q3, sat)
        vecs.push_back(mk("legacy",      2'b00, 13, 1'b0, 'h0A000, 'h3FFFF, 0, 0,       4'h5, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk("rounding",    2'b10,  4, 1'b1, 24, 23, -24, 0,               4'h2, 4'h1, 4'hF, 4'h0, 1'b0));
        vecs.push_back(mk("relu_sat",    2'b00,  0, 1'b0, 100, 0, 0, 0,                4'hF, 4'h0, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk("ident_sat",   2'b10,  0, 1'b0, -100, 0, 0, 0,               4'h8, 4'h0, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk("leaky",       2'b01,  0, 1'b0, -16, -1, 7, 0,                4'hE, 4'hF, 4'h7, 4'h0, 1'b0));
        vecs.push_back(mk("rsvd_relu",   2'b11,  0, 1'b0, -5, 9, 15, 0,                 4'h0, 4'h9, 4'hF, 4'h0, 1'b0));
        vecs.push_back(mk("shift_18",    2'b10, 18, 1'b1, -5, 1000, 0, 0,              4'hF, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk("shift_31",    2'b10, 31, 1'b1, -131072, 131071, 0, 0,       4'hF, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk("shift_17_rnd",2'b10, 17, 1'b1, 131071, -131072, 65536, 0,   4'h1, 4'hF, 4'h1, 4'h0, 1'b0));
        vecs.push_back(mk("ident_edge",  2'b10,  0, 1'b0, 7, -8, 8, 0,                  4'h7, 4'h8, 4'h7, 4'h0, 1'b1));
        vecs.push_back(mk("leaky_sat",   2'b01,  0, 1'b0, -100, 100, 0, 0,              4'h8, 4'h7, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk("relu_rnd_sat",2'b00,  1, 1'b1, 131071, 0, 0, 0,              4'hF, 4'h0, 4'h0, 4'h0, 1'b1));
        vecs.push_back(mk("rnd_shift0",  2'b10,  0, 1'b1, 3, -3, 0, 0,                  4'h3, 4'hD, 4'h0, 4'h0, 1'b0));

        rst_n = 1'b0; in_valid = 1'b0; act_in = '0; mode = '0; shift = '0;
        round_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_valid", {255'b0, out_valid}, 0);
        check("reset act_out",   act_out, 0);
        check("reset out_sat",   {255'b0, out_sat}, 0);
        check("reset in_ready",  {255'b0, in_ready}, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Backpressure: A and B fill the pipe and C must wait.
        a = mk("A", 2'b10, 0, 1'b0, 1, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
        b = mk("B", 2'b10, 0, 1'b0, 2, 0, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
        c = mk("C", 2'b10, 0, 1'b0, 3, 0, 0, 0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(a); in_valid = 1'b1;
        @(negedge clk); drive(b);
        @(negedge clk); drive(c);
        check("bp in_ready low", {255'b0, in_ready}, 0);
        check("bp A on output",  act_out, expected(a));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp A held",  act_out, expected(a));
            check("bp valid held", {255'b0, out_valid}, 1);
        end
        out_ready = 1'b1;
        c_acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) got.push_back(int'(act_out[OW-1:0]));
            if (in_valid && in_ready) c_acc = 1'b1;
            @(negedge clk);
            if (c_acc) in_valid = 1'b0;
        end
        check("bp C accepted", {255'b0, c_acc}, 1);
        check("bp output count", (OW*N)'(got.size()), 3);
        for (int i = 0; i < 3; i++)
            check("bp order", (OW*N)'(got.size() > i ? got[i] : 255), (OW*N)'(i + 1));

        // Reset with two vectors in flight.
        a = mk("R1", 2'b10, 0, 1'b0, 100, 0, 0, 0, 4'h7, 4'h0, 4'h0, 4'h0, 1'b1);
        b = mk("R2", 2'b10, 0, 1'b0, 6, 0, 0, 0, 4'h6, 4'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk); drive(a); in_valid = 1'b1;
        @(negedge clk); drive(b);
        @(negedge clk); in_valid = 1'b0;
        check("rst pipe busy", {255'b0, out_valid}, 1);
        check("rst R1 sat",    {255'b0, out_sat}, 1);
        rst_n = 1'b0;
        #1;
        check("rst in_ready", {255'b0, in_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst out_valid", {255'b0, out_valid}, 0);
        check("rst act_out",   act_out, 0);
        check("rst out_sat",   {255'b0, out_sat}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst no stale output", {255'b0, out_valid}, 0);
        end
        apply_vec(mk("post_reset", 2'b10, 0, 1'b0, 7, 0, 0, 0, 4'h7, 4'h0, 4'h0, 4'h0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
